// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receive path.
//   state_t          receiver FSM states
//   FRAME_DATA_BITS  data bits per device-to-host frame
//   START_BIT/STOP_BIT  expected framing levels
//   BREAK_PREFIX/EXT_PREFIX  scan-code prefixes for downstream decoders
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_in_filter.sv
// ps2_in_filter: conditions the raw PS/2 lines.
//   Both lines pass a 2-FF synchronizer. The synchronized clock is debounced:
//   the filtered level follows it only after FILTER_LEN consecutive samples
//   that differ from the current filtered level.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   ps2_clk    raw keyboard clock (asynchronous)
//   ps2_data   raw keyboard data (asynchronous)
//   data_sync  synchronized keyboard data
//   fall       one-cycle pulse when the filtered clock goes 1->0
module ps2_in_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic           clk_p0;
  logic           clk_p1;
  logic           dat_p0;
  logic           filt;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      dat_p0    <= 1'b1;
      data_sync <= 1'b1;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      // synchronizer stage 0 -> stage 1
      clk_p0    <= ps2_clk;
      clk_p1    <= clk_p0;
      dat_p0    <= ps2_data;
      data_sync <= dat_p0;

      // debounce: count consecutive samples disagreeing with the filtered level;
      // a single agreeing sample restarts the count
      fall <= 1'b0;
      if (clk_p1 != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt <= clk_p1;
          cnt  <= '0;
          fall <= filt;  // only a 1->0 transition produces a pulse
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_code_rx.sv
// ps2_code_rx: deframes 11-bit PS/2 device-to-host frames into bytes and keeps
// a two-byte history for a 4-digit hex display.
// Optional build macro PS2_PARITY_CHECK_EN: when defined a frame is accepted
// only if data bits plus parity have odd population; otherwise parity is
// sampled and ignored.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   ps2_clk     raw keyboard clock (asynchronous)
//   ps2_data    raw keyboard data (asynchronous)
//   code        {previous byte, latest byte}
//   byte_out    latest accepted byte
//   byte_valid  one-cycle pulse when a byte is accepted
//   frame_err   one-cycle pulse on a rejected or timed-out frame
module ps2_code_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic           data_sync;
  logic           fall;
  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TW-1:0]  tcnt;
  logic           accept;

  ps2_in_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall      (fall)
  );

  // evaluated in the stop-bit fall cycle
  assign accept = (data_sync == STOP_BIT) &&
                  (!PARITY_CHECK || (^{shreg, par_bit}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      code       <= 16'h0000;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall) begin
        // a fall always wins over a coincident timeout
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (data_sync == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_sync, shreg[7:1]};  // LSB first
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          STOP: begin
            if (accept) begin
              byte_out   <= shreg;
              code       <= {code[7:0], shreg};
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // keyboard stopped clocking mid-frame: drop the partial byte
        state     <= IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_code_rx.sv
module tb_ps2_code_rx;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] code;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_err;

  ps2_code_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [7:0]  b;
    logic [15:0] code;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] model_code = 16'h0000;
  logic [7:0]  model_byte = 8'h00;
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // scoreboard: every byte_valid / frame_err pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && (byte_valid || frame_err)) begin
      chk("excl", 32'(byte_valid & frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, byte_valid, frame_err}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("kind_err", 32'(frame_err), 32'(e.err));
        chk("byte_out", 32'(byte_out), 32'(e.b));
        chk("code", 32'(code), 32'(e.code));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    @(posedge clk);
    ps2_data = v;
    cycles(HALF / 2);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
    cycles(HALF / 2);
  endtask

  // record the outcome a correct receiver must produce for this frame
  task automatic expect_frame(input logic [7:0] b, input logic par, input logic stop);
    logic ok;
    ev_t  e;
    ok = stop && (!PCHK || (^{b, par}));
    if (ok) begin
      model_code = {model_code[7:0], b};
      model_byte = b;
    end
    e.err  = !ok;
    e.b    = model_byte;
    e.code = model_code;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    expect_frame(b, par, stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    cycles(5);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_code", 32'(code), 32'h0000);
    chk("rst_byte", 32'(byte_out), 32'h00);
    chk("rst_bv", 32'(byte_valid), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);

    // idle lines: nothing may pulse
    cycles(1000);
    @(negedge clk);
    chk("idle_code", 32'(code), 32'h0000);

    // single good frame
    send_frame(8'h1D, 1'b1, 1'b1);
    drain("drain_1d");
    @(negedge clk);
    chk("code_001d", 32'(code), 32'h001D);

    // back-to-back break sequence
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1D, 1'b1, 1'b1);
    drain("drain_f01d");
    @(negedge clk);
    chk("code_f01d", 32'(code), 32'hF01D);

    // bad stop bit
    send_frame(8'h1D, 1'b1, 1'b0);
    drain("drain_badstop");
    @(negedge clk);
    chk("code_badstop", 32'(code), 32'(model_code));

    // wrong parity, good stop
    send_frame(8'h1D, 1'b0, 1'b1);
    drain("drain_badpar");
    @(negedge clk);
    chk("code_badpar", 32'(code), 32'(model_code));

    // timeout after start + 4 data bits
    begin
      ev_t e;
      e.err = 1'b1; e.b = model_byte; e.code = model_code;
      exp_q.push_back(e);
    end
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    cycles(TO + 100);
    drain("drain_timeout");
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("drain_1c");
    @(negedge clk);
    chk("code_xx1c", 32'(code[7:0]), 32'h1C);
    chk("code_1c_full", 32'(code), 32'(model_code));

    // sub-threshold glitch while data looks like a start bit
    @(posedge clk);
    ps2_data = 1'b0;
    cycles(2);
    ps2_clk = 1'b0;
    cycles(FL - 1);
    ps2_clk = 1'b1;
    cycles(10);
    ps2_data = 1'b1;
    cycles(50);
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("drain_glitch");
    @(negedge clk);
    chk("code_glitch", 32'(code), 32'(model_code));

    // reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    @(posedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    model_code = 16'h0000;
    model_byte = 8'h00;
    @(negedge clk);
    chk("code_midrst", 32'(code), 32'h0000);
    chk("byte_midrst", 32'(byte_out), 32'h00);
    cycles(20);
    send_frame(8'h2A, 1'b0, 1'b1);
    drain("drain_after_rst");
    @(negedge clk);
    chk("code_after_rst", 32'(code), 32'h002A);

    cycles(50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_code_rx.md
Name: ps2_code_rx

Overview:
- Receives raw PS/2 keyboard clock/data lines and deframes 11-bit PS/2 device-to-host frames into bytes.
- Maintains a 16-bit history of the last two received bytes (e.g. F0 1D for a break code) as code[15:0].
- code drives the downstream 4-digit hex seven-segment decoder directly.
- Sits between the board PS/2 pins and the display path.

Parameters:
FILTER_LEN, 8, consecutive clk cycles the synchronized ps2_clk must be stable before the filtered level changes (min 2)
TIMEOUT_CYCLES, 50000, max clk cycles between filtered falling edges inside a frame before abort (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw keyboard clock, asynchronous
ps2_data  input  1  raw keyboard data, asynchronous
code  output  16  {previous byte, latest byte}; to hex decoder
byte_out  output  8  latest accepted byte
byte_valid  output  1  one-cycle pulse when a byte is accepted
frame_err  output  1  one-cycle pulse on a rejected or aborted frame

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: code=16'h0000, byte_out=8'h00, byte_valid=0, frame_err=0, FSM=IDLE, filtered clk=1, all counters 0.
- Input conditioning: ps2_clk and ps2_data each pass a 2-FF synchronizer.
- Filtered clk takes the synchronized ps2_clk value after FILTER_LEN consecutive equal samples that differ from the current filtered value.
- fall pulse = 1 cycle when filtered clk goes 1->0. Data is sampled from synchronized ps2_data in the fall cycle.
- FSM is advanced only by fall, except for timeout:
  - IDLE: on fall with data=0 (start bit) -> DATA, bit_cnt=0. On fall with data=1, stay IDLE (no error).
  - DATA: shift in LSB-first; after 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: on fall, if data=1 and the frame is accepted -> byte accepted; else frame_err. Always -> IDLE.
- Byte accept, on the clk edge after the stop-bit fall cycle:
  - byte_out <= byte.
  - code <= {code[7:0], byte}.
  - byte_valid=1 for exactly one cycle.
- Timeout: cycle counter clears on every fall and while in IDLE.
  - In DATA/PARITY/STOP, when the counter reaches TIMEOUT_CYCLES-1: -> IDLE, frame_err pulse, partial byte discarded.
  - fall in the same cycle as timeout: fall wins and the counter clears.
- Rejected or aborted frames leave code and byte_out unchanged.
- rst mid-frame: partial frame discarded, code cleared to 0000. A keyboard frame already in flight is not resynchronized until the next start bit seen in IDLE.
- byte_valid and frame_err are never asserted in the same cycle.
- Back-to-back frames (about 1.1 ms apart at 10 kHz) need no idle gap beyond the stop bit.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the frame is accepted only if the 8 data bits plus the parity bit have odd population. Bad parity with a good stop bit gives a frame_err pulse, and code is unchanged.
- Undefined: the parity bit is sampled and ignored; frame_err arises only from a bad stop bit or timeout.
- The port list is identical either way.

Decomposition:
- Package ps2_pkg:
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - FRAME_DATA_BITS=8.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - BREAK_PREFIX=8'hF0, EXT_PREFIX=8'hE0, for downstream use.
- Sub-module ps2_in_filter:
  - Contains the synchronizers, FILTER_LEN debounce and fall-pulse generation.
  - Outputs data_sync and fall.
- ps2_code_rx instantiates ps2_in_filter and holds the FSM, shifter, timeout counter and code register.

Test Plan:
- Reset then idle lines high for 1000 cycles -> code=0000, byte_valid never pulses, frame_err never pulses.
- Frame 0x1D at 10 kHz (data bits 1,0,1,1,1,0,0,0, parity 1, stop 1) -> one byte_valid pulse, byte_out=1D, code=001D.
- Frames F0 then 1D back-to-back after the previous test -> code=1DF0 then F01D; exactly two byte_valid pulses.
- 1D frame with stop bit 0 -> frame_err pulse, code unchanged. Parity forced to 0:
  - with PS2_PARITY_CHECK_EN: frame_err, code unchanged.
  - without: byte_valid, code updated.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, return to IDLE; next clean 0x1C frame gives code=xx1C.
- Glitch on ps2_clk low for FILTER_LEN-1 cycles -> no fall, no state change. rst asserted mid-frame -> code=0000; next full frame accepted.
